// File: rtl/pdm_pkg.sv
// Shared constants for the PDM audio output path: default widths, the
// second-order input clamp and the modulator reset values.
package pdm_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_FIFO_DEPTH = 4;
    localparam int DEF_OSR_WIDTH  = 8;

    // Integrator headroom above the sample width for the second-order loop.
    localparam int INT_GUARD_BITS = 4;
    localparam int INT_RESET      = 0;

    // Clamp at 7/8 of full scale keeps the second-order loop stable.
    localparam int CLAMP_NUM   = 7;
    localparam int CLAMP_SHIFT = 3;

    function automatic int half_scale(input int w);
        return 2 ** (w - 1);
    endfunction

    function automatic int clamp_limit(input int w);
        return (CLAMP_NUM * half_scale(w)) >> CLAMP_SHIFT;
    endfunction

    function automatic int acc_reset(input int w);
        return half_scale(w);
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// Power-of-two sample FIFO with occupancy count; the head entry is always
// visible on rd_data.
module sample_fifo #(
    parameter  int DATA_WIDTH = 8,
    parameter  int DEPTH      = 4,
    localparam int AW         = $clog2(DEPTH),
    localparam int LW         = AW + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [LW-1:0]         level,
    output logic                  full,
    output logic                  empty
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic                  push_ok;
    logic                  pop_ok;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok && !rst) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/pdm_audio_out.sv
// PDM audio output: sample FIFO, sample-rate counter and a 1-bit modulator.
// First-order by default; define PDM_SECOND_ORDER_EN for the second-order loop.
module pdm_audio_out
    import pdm_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int OSR_WIDTH  = DEF_OSR_WIDTH
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           en_i,
    input  logic [OSR_WIDTH-1:0]           osr_i,
    input  logic [DATA_WIDTH-1:0]          sample_i,
    input  logic                           sample_valid_i,
    output logic                           sample_ready_o,
    input  logic                           clr_underrun_i,
    output logic                           pdm_o,
    output logic                           underrun_o,
    output logic [$clog2(FIFO_DEPTH):0]    fifo_level_o
);

    logic [OSR_WIDTH-1:0]  cnt;
    logic [OSR_WIDTH-1:0]  cnt_next;
    logic                  tick;
    logic                  push;
    logic                  pop;
    logic                  full;
    logic                  empty;
    logic [DATA_WIDTH-1:0] head;
    logic [DATA_WIDTH-1:0] cur;

    assign sample_ready_o = ~full;
    assign push           = sample_valid_i & sample_ready_o;
    assign pop            = tick & ~empty;

    sample_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk_i),
        .rst     (rst_i),
        .push    (push),
        .pop     (pop),
        .wr_data (sample_i),
        .rd_data (head),
        .level   (fifo_level_o),
        .full    (full),
        .empty   (empty)
    );

    // A shrinking osr_i can leave the count beyond the new limit; restart silently.
    always_comb begin
        tick     = 1'b0;
        cnt_next = '0;
        if (en_i) begin
            if (cnt == osr_i) begin
                tick = 1'b1;
            end else if (cnt < osr_i) begin
                cnt_next = cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt        <= '0;
            cur        <= '0;
            underrun_o <= 1'b0;
        end else begin
            cnt <= cnt_next;
            if (pop) begin
                cur <= head;
            end
            if (tick && empty) begin
                underrun_o <= 1'b1;
            end else if (clr_underrun_i) begin
                underrun_o <= 1'b0;
            end
        end
    end

`ifdef PDM_SECOND_ORDER_EN
    localparam int IW = DATA_WIDTH + INT_GUARD_BITS;
    localparam logic signed [IW-1:0] X_MAX  = IW'(clamp_limit(DATA_WIDTH));
    localparam logic signed [IW-1:0] X_MIN  = -X_MAX;
    localparam logic signed [IW-1:0] FB_POS = IW'(half_scale(DATA_WIDTH));
    localparam logic signed [IW-1:0] FB_NEG = -FB_POS;

    logic signed [IW-1:0] i1;
    logic signed [IW-1:0] i2;
    logic signed [IW-1:0] sx;
    logic signed [IW-1:0] x;
    logic signed [IW-1:0] fb;
    logic                 y;

    always_comb begin
        sx = IW'($signed(cur));
        x  = sx;
        if (sx > X_MAX) begin
            x = X_MAX;
        end else if (sx < X_MIN) begin
            x = X_MIN;
        end
        y  = ~i2[IW-1];
        fb = y ? FB_POS : FB_NEG;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || !en_i) begin
            i1    <= IW'(INT_RESET);
            i2    <= IW'(INT_RESET);
            pdm_o <= 1'b0;
        end else begin
            i1    <= i1 + x - fb;
            i2    <= i2 + i1 - fb;
            pdm_o <= y;
        end
    end
`else
    localparam logic [DATA_WIDTH-1:0] ACC_RST = DATA_WIDTH'(acc_reset(DATA_WIDTH));

    logic [DATA_WIDTH-1:0] acc;
    logic [DATA_WIDTH-1:0] u;
    logic [DATA_WIDTH:0]   sum;

    // Offset-binary input makes the carry density track the signed sample.
    assign u   = {~cur[DATA_WIDTH-1], cur[DATA_WIDTH-2:0]};
    assign sum = {1'b0, acc} + {1'b0, u};

    always_ff @(posedge clk_i) begin
        if (rst_i || !en_i) begin
            acc   <= ACC_RST;
            pdm_o <= 1'b0;
        end else begin
            acc   <= sum[DATA_WIDTH-1:0];
            pdm_o <= sum[DATA_WIDTH];
        end
    end
`endif

endmodule

// File: tb/tb_pdm_audio_out.sv
// Bench for pdm_audio_out (first-order build): directed scenarios followed by
// random traffic, all checked against a queue-based reference model.
module tb_pdm_audio_out;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       en_i;
    logic [7:0] osr_i;
    logic [7:0] sample_i;
    logic       sample_valid_i;
    logic       sample_ready_o;
    logic       clr_underrun_i;
    logic       pdm_o;
    logic       underrun_o;
    logic [2:0] fifo_level_o;

    int checks = 0;
    int errors = 0;

    int q[$];
    int m_cnt;
    int m_cur;
    int m_acc;
    int m_pdm;
    int m_und;

    always #5 clk_i = ~clk_i;

    pdm_audio_out dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .en_i           (en_i),
        .osr_i          (osr_i),
        .sample_i       (sample_i),
        .sample_valid_i (sample_valid_i),
        .sample_ready_o (sample_ready_o),
        .clr_underrun_i (clr_underrun_i),
        .pdm_o          (pdm_o),
        .underrun_o     (underrun_o),
        .fifo_level_o   (fifo_level_o)
    );

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock edge of the reference: density modulator as integer arithmetic mod 256.
    task automatic model_edge(input bit rst, input bit en, input bit valid,
                              input bit clr, input int osr, input int smp);
        bit tick;
        bit was_empty;
        bit accepted;
        int s;
        if (rst) begin
            q.delete();
            m_cnt = 0;
            m_cur = 0;
            m_acc = 128;
            m_pdm = 0;
            m_und = 0;
            return;
        end
        was_empty = (q.size() == 0);
        accepted  = valid && (q.size() < 4);
        tick      = 1'b0;
        if (!en) m_cnt = 0;
        else if (m_cnt == osr) begin
            tick  = 1'b1;
            m_cnt = 0;
        end else if (m_cnt > osr) m_cnt = 0;
        else m_cnt++;
        if (en) begin
            s     = m_acc + (m_cur ^ 128);
            m_pdm = (s >= 256) ? 1 : 0;
            m_acc = s % 256;
        end else begin
            m_acc = 128;
            m_pdm = 0;
        end
        if (tick && was_empty) m_und = 1;
        else if (clr) m_und = 0;
        if (tick && !was_empty) m_cur = q.pop_front();
        if (accepted) q.push_back(smp & 255);
    endtask

    task automatic apply_stimulus(input bit rst, input bit en, input bit valid,
                                  input bit clr, input int osr, input int smp);
        @(negedge clk_i);
        rst_i          = rst;
        en_i           = en;
        valid_drive(valid);
        clr_underrun_i = clr;
        osr_i          = osr[7:0];
        sample_i       = smp[7:0];
        #1;
        check_output("ready", 32'(sample_ready_o), 32'(q.size() < 4));
        @(posedge clk_i);
        model_edge(rst, en, valid, clr, osr, smp);
        #1;
        check_output("pdm", 32'(pdm_o), 32'(m_pdm));
        check_output("underrun", 32'(underrun_o), 32'(m_und));
        check_output("level", 32'(fifo_level_o), 32'(q.size()));
    endtask

    task automatic valid_drive(input bit v);
        sample_valid_i = v;
    endtask

    initial begin
        int ones;
        rst_i          = 1'b1;
        en_i           = 1'b0;
        osr_i          = 8'd0;
        sample_i       = 8'd0;
        sample_valid_i = 1'b0;
        clr_underrun_i = 1'b0;
        repeat (2) @(posedge clk_i);
        model_edge(1, 0, 0, 0, 0, 0);
        #1;
        check_output("reset_level", 32'(fifo_level_o), 32'd0);
        check_output("reset_ready", 32'(sample_ready_o), 32'd1);
        check_output("reset_pdm", 32'(pdm_o), 32'd0);
        check_output("reset_underrun", 32'(underrun_o), 32'd0);

        // Fill while disabled: fifth push must be refused.
        for (int i = 0; i < 5; i++) apply_stimulus(0, 0, 1, 0, 0, 8'h10 + i);
        check_output("full_level", 32'(fifo_level_o), 32'd4);
        check_output("full_ready", 32'(sample_ready_o), 32'd0);

        // One pop to reach level 3, then reset with a sample offered.
        apply_stimulus(0, 1, 0, 0, 0, 0);
        apply_stimulus(0, 1, 0, 0, 3, 0);
        apply_stimulus(1, 1, 1, 0, 3, 8'h55);
        check_output("midreset_level", 32'(fifo_level_o), 32'd0);
        check_output("midreset_pdm", 32'(pdm_o), 32'd0);

        // Mid-scale sample gives alternating output.
        apply_stimulus(0, 0, 1, 0, 3, 8'h00);
        for (int i = 0; i < 40; i++) apply_stimulus(0, 1, 0, 0, 3, 0);

        // Single sample at osr 7: pop on the 8th tick edge, underrun on the 16th.
        apply_stimulus(1, 0, 0, 0, 7, 0);
        apply_stimulus(0, 0, 1, 0, 7, 8'hA5);
        for (int i = 1; i <= 17; i++) begin
            apply_stimulus(0, 1, 0, 0, 7, 0);
            if (i == 8) check_output("osr7_popped", 32'(fifo_level_o), 32'd0);
            if (i == 16) check_output("osr7_underrun", 32'(underrun_o), 32'd1);
        end
        apply_stimulus(0, 1, 0, 1, 7, 0);
        check_output("osr7_cleared", 32'(underrun_o), 32'd0);

        // Near full-scale positive: 255 ones in any 256-cycle window.
        apply_stimulus(1, 0, 0, 0, 0, 0);
        apply_stimulus(0, 0, 1, 0, 0, 8'h7F);
        apply_stimulus(0, 1, 0, 0, 0, 0);
        ones = 0;
        for (int i = 0; i < 256; i++) begin
            apply_stimulus(0, 1, 0, 0, 0, 0);
            ones += int'(pdm_o);
        end
        check_output("density_7f", 32'(ones), 32'd255);

        begin
            bit en_r = 1'b1;
            int osr_r = 2;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(49) == 0) en_r = ~en_r;
                if ($urandom_range(29) == 0) osr_r = $urandom_range(12);
                apply_stimulus($urandom_range(499) == 0, en_r,
                               $urandom_range(2) == 0, $urandom_range(19) == 0,
                               osr_r, $urandom_range(255));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
